pin_lane_scheduler: RTL and testbench

- Shares one narrow registered output lane among NREQ requesters. Each requester submits one word of arbitrary width, from 1 bit up to DATA_W bits, covering the 1/8/16/32/64/65/128/513-bit pin classes.
- Arbitration is round-robin. The granted word is captured, then serialized LSB-first into LANE_W-bit beats under a valid/ready handshake.
- Sits between the wide-pin register stage and a shared narrow transport to the testbench or SystemC side.

---
 rtl/pin_lane_scheduler_if.sv | 45 ++++
 rtl/pin_lane_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_pin_lane_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_lane_scheduler_if.sv
// Bundle of request and lane signals shared between the requesters/sink
// (master side) and pin_lane_scheduler (slave side).
// Optional PIN_LANE_SCHEDULER_PARITY_EN adds lane_par / lane_par_err.
interface pin_lane_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int LANE_W = 32,
  parameter int DATA_W = 513,
  parameter int WID_W  = 10
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*WID_W-1:0]  req_len;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic                   lane_valid;
  logic                   lane_ready;
  logic [LANE_W-1:0]      lane_data;
  logic [ID_W-1:0]        lane_id;
  logic                   lane_last;
  logic                   busy;
`ifdef PIN_LANE_SCHEDULER_PARITY_EN
  logic                   lane_par;
  logic                   lane_par_err;

  modport master (
    output req, req_len, req_data, lane_ready, lane_par_err,
    input  ack, err, lane_valid, lane_data, lane_id, lane_last, busy, lane_par
  );
  modport slave (
    input  req, req_len, req_data, lane_ready, lane_par_err,
    output ack, err, lane_valid, lane_data, lane_id, lane_last, busy, lane_par
  );
`else
  modport master (
    output req, req_len, req_data, lane_ready,
    input  ack, err, lane_valid, lane_data, lane_id, lane_last, busy
  );
  modport slave (
    input  req, req_len, req_data, lane_ready,
    output ack, err, lane_valid, lane_data, lane_id, lane_last, busy
  );
`endif
endinterface

// File: rtl/pin_lane_scheduler.sv
// Round-robin scheduler that captures one requester's word (1..DATA_W bits)
// and serializes it LSB-first onto a shared LANE_W-bit valid/ready lane.
// Optional feature macro: PIN_LANE_SCHEDULER_PARITY_EN (lane parity and
// sink-requested beat replay).
module pin_lane_scheduler #(
  parameter int NREQ   = 4,
  parameter int LANE_W = 32,
  parameter int DATA_W = 513,
  parameter int WID_W  = 10
) (
  input logic clk,
  input logic rst_n,
  pin_lane_scheduler_if.slave bus
);
  localparam int ID_W      = $clog2(NREQ);
  localparam int CNT_W     = WID_W + 1;
  localparam int BEATS_MAX = (DATA_W + LANE_W - 1) / LANE_W;
  localparam int PAD_W     = BEATS_MAX * LANE_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [1:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gid;
  logic [NREQ-1:0]   ack_q;
  logic              err_q;
  logic              valid_q;
  logic              last_q;
  logic [LANE_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  beats;
  logic [CNT_W-1:0]  beat_cnt;
  logic [PAD_W-1:0]  cap_data;

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] masked_data;
  logic [WID_W-1:0]  sel_len;
  logic [CNT_W-1:0]  sel_beats;
  logic              sel_illegal;
  logic [NREQ-1:0]   req_live;
  logic [NREQ-1:0]   send_req;
  logic              accept;

  // First set bit of r at or after ptr, searching upward with wrap.
  function automatic logic [ID_W-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] res;
    logic [ID_W-1:0] cand;
    logic            found;
    int              idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!found && r[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Beat n of the captured, zero-padded word.
  function automatic logic [LANE_W-1:0] beat_at(input logic [CNT_W-1:0] n);
    logic [LANE_W-1:0] b;
    b = '0;
    for (int k = 0; k < BEATS_MAX; k++)
      if (n == CNT_W'(k)) b = cap_data[k*LANE_W +: LANE_W];
    return b;
  endfunction

  // Reset asserts asynchronously and releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};

  assign rst_int_n = rst_sync[1];

  // Select the granted requester's word and length.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++)
      if (gid == ID_W'(i)) begin
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
        sel_len  = bus.req_len[i*WID_W +: WID_W];
      end
  end

  // Zero every bit at or above the declared length before capture.
  always_comb begin
    for (int i = 0; i < DATA_W; i++)
      masked_data[i] = sel_data[i] & (i < int'(sel_len));
  end

  assign sel_beats   = (CNT_W'(sel_len) + CNT_W'(LANE_W - 1)) / CNT_W'(LANE_W);
  assign sel_illegal = (sel_len == '0) || (sel_len > WID_W'(DATA_W));

  // A requester's req is ignored during its ack cycle; the word in flight is excluded at handover.
  assign req_live = bus.req & ~ack_q;
  assign send_req = req_live & ~(NREQ'(1) << id_q);

`ifdef PIN_LANE_SCHEDULER_PARITY_EN
  assign accept       = valid_q & bus.lane_ready & ~bus.lane_par_err;
  assign bus.lane_par = ^data_q;
`else
  assign accept = valid_q & bus.lane_ready;
`endif

  // Captured word store; contents are only read after a GRANT has loaded them.
  always_ff @(posedge clk)
    // NOTE: the wide datapath register is deliberately not reset; control state guards every read.
    if (state == GRANT) cap_data <= PAD_W'(masked_data);

  // Arbitration FSM and registered lane outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gid      <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      beats    <= '0;
      beat_cnt <= '0;
    end else begin
      // NOTE: state uses <= so every branch sees the pre-edge values of all registers.
      ack_q <= '0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_live) begin
            gid   <= pick(req_live, rr_ptr);
            state <= GRANT;
          end
        end
        GRANT: begin
          ack_q    <= NREQ'(1) << gid;
          id_q     <= gid;
          rr_ptr   <= (gid == ID_W'(NREQ - 1)) ? '0 : gid + 1'b1;
          beats    <= sel_beats;
          beat_cnt <= '0;
          if (sel_illegal) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        SEND: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= beat_at(beat_cnt);
            last_q  <= (beat_cnt == beats - 1'b1);
          end else if (accept) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              if (|send_req) begin
                gid   <= pick(send_req, rr_ptr);
                state <= GRANT;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              data_q   <= beat_at(beat_cnt + 1'b1);
              last_q   <= ((beat_cnt + 1'b1) == (beats - 1'b1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.lane_valid = valid_q;
  assign bus.lane_data  = data_q;
  assign bus.lane_id    = id_q;
  assign bus.lane_last  = last_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_pin_lane_scheduler.sv
// Directed self-checking bench for pin_lane_scheduler (4 requesters,
// 32-bit lane, 513-bit words).
module tb_pin_lane_scheduler;
  localparam int NREQ   = 4;
  localparam int LANE_W = 32;
  localparam int DATA_W = 513;
  localparam int WID_W  = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0]  exp_b [0:16];
  logic [512:0] word;

  pin_lane_scheduler_if #(.NREQ(NREQ), .LANE_W(LANE_W), .DATA_W(DATA_W), .WID_W(WID_W)) bus ();

  pin_lane_scheduler #(.NREQ(NREQ), .LANE_W(LANE_W), .DATA_W(DATA_W), .WID_W(WID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int i, input int len, input logic [512:0] d);
    bus.req_len[i*WID_W +: WID_W]    = WID_W'(len);
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req[i]                       = 1'b1;
  endtask

  // Wait for the next ack, compare it, then drop the acked requests.
  task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input logic exp_err);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack == '0 && cyc < 12);
    check({tag, "_ack"}, 64'(bus.ack), 64'(exp_ack));
    check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    bus.req = bus.req & ~bus.ack;
  endtask

  // Collect nb beats against exp_b; optional ready toggling and first-beat latency.
  task automatic run_word(input string tag, input int id, input int nb, input int total,
                          input bit toggle, input int first_lat);
    int   got;
    int   cyc;
    bit   phase;
    bit   stalled;
    bit   seen;
    logic [31:0] held_d;
    logic        held_l;
    got = 0; cyc = 0; phase = 1'b1; stalled = 1'b0; seen = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (got < nb && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (toggle) begin
        bus.lane_ready = phase;
        phase = ~phase;
      end else begin
        bus.lane_ready = 1'b1;
      end
      if (stalled) begin
        check({tag, "_hold_data"}, 64'(bus.lane_data), 64'(held_d));
        check({tag, "_hold_last"}, 64'(bus.lane_last), 64'(held_l));
        stalled = 1'b0;
      end
      if (bus.lane_valid) begin
        if (!seen && first_lat > 0) check({tag, "_first_lat"}, 64'(cyc), 64'(first_lat));
        seen = 1'b1;
        if (bus.lane_ready) begin
          check({tag, "_data"}, 64'(bus.lane_data), 64'(exp_b[got]));
          check({tag, "_last"}, 64'(bus.lane_last), 64'(got == total - 1));
          check({tag, "_id"}, 64'(bus.lane_id), 64'(id));
          got++;
        end else begin
          stalled = 1'b1;
          held_d  = bus.lane_data;
          held_l  = bus.lane_last;
        end
      end
    end
    if (got < nb) check({tag, "_beats"}, 64'(got), 64'(nb));
    bus.lane_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.req_data   = '0;
    bus.lane_ready = 1'b1;
`ifdef PIN_LANE_SCHEDULER_PARITY_EN
    bus.lane_par_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'h0);
    check("rst_err", 64'(bus.err), 64'h0);
    check("rst_valid", 64'(bus.lane_valid), 64'h0);
    check("rst_last", 64'(bus.lane_last), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_data", 64'(bus.lane_data), 64'h0);
    check("rst_id", 64'(bus.lane_id), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // T1: 1-bit word, exact latencies.
    word = '0; word[0] = 1'b1;
    set_word(0, 1, word);
    @(negedge clk);
    check("t1_ack_early", 64'(bus.ack), 64'h0);
    @(negedge clk);
    check("t1_ack_lat", 64'(bus.ack), 64'h1);
    check("t1_err", 64'(bus.err), 64'h0);
    check("t1_valid_wait", 64'(bus.lane_valid), 64'h0);
    check("t1_busy", 64'(bus.busy), 64'h1);
    bus.req[0] = 1'b0;
    exp_b[0] = 32'h0000_0001;
    run_word("t1", 0, 1, 1, 1'b0, 1);
    @(negedge clk);
    check("t1_idle_valid", 64'(bus.lane_valid), 64'h0);
    check("t1_idle_busy", 64'(bus.busy), 64'h0);

    // T2: 65-bit word on requester 1; bit 70 lies above len and must vanish.
    word = '0;
    word[63:0] = 64'hDEADBEEF_CAFEF00D;
    word[64] = 1'b1;
    word[70] = 1'b1;
    set_word(1, 65, word);
    wait_ack("t2", 4'b0010, 1'b0);
    exp_b[0] = 32'hCAFEF00D; exp_b[1] = 32'hDEADBEEF; exp_b[2] = 32'h0000_0001;
    run_word("t2", 1, 3, 3, 1'b0, 1);

    // T3: full 513-bit all-ones word with ready toggling.
    word = '1;
    set_word(2, 513, word);
    wait_ack("t3", 4'b0100, 1'b0);
    for (int b = 0; b < 16; b++) exp_b[b] = 32'hFFFF_FFFF;
    exp_b[16] = 32'h0000_0001;
    run_word("t3", 2, 17, 17, 1'b1, 0);

    // Requester 3 single byte, moves the pointer back to 0.
    word = '0; word[7:0] = 8'h77;
    set_word(3, 8, word);
    wait_ack("t3b", 4'b1000, 1'b0);
    exp_b[0] = 32'h0000_0077;
    run_word("t3b", 3, 1, 1, 1'b0, 0);

    // T4: all four requesting; round-robin 0,1,2,3 then a re-raised 0.
    word = '0; word[8:0] = 9'h1A5;    set_word(0, 8, word);
    word = '0; word[15:0] = 16'hBEEF; set_word(1, 16, word);
    word = '0; word[31:0] = 32'h12345678; set_word(2, 32, word);
    word = '0; word[63:0] = 64'h01234567_89ABCDEF; set_word(3, 64, word);
    wait_ack("t4_g0", 4'b0001, 1'b0);
    exp_b[0] = 32'h0000_00A5;
    run_word("t4_w0", 0, 1, 1, 1'b0, 0);
    wait_ack("t4_g1", 4'b0010, 1'b0);
    exp_b[0] = 32'h0000_BEEF;
    run_word("t4_w1", 1, 1, 1, 1'b0, 0);
    wait_ack("t4_g2", 4'b0100, 1'b0);
    word = '0; word[7:0] = 8'h3C; set_word(0, 8, word);
    exp_b[0] = 32'h12345678;
    run_word("t4_w2", 2, 1, 1, 1'b0, 0);
    wait_ack("t4_g3", 4'b1000, 1'b0);
    exp_b[0] = 32'h89ABCDEF; exp_b[1] = 32'h01234567;
    run_word("t4_w3", 3, 2, 2, 1'b0, 0);
    wait_ack("t4_g0b", 4'b0001, 1'b0);
    exp_b[0] = 32'h0000_003C;
    run_word("t4_w0b", 0, 1, 1, 1'b0, 0);

    // T5: illegal lengths on requester 2, then pointer must sit at 3.
    word = '0; word[3:0] = 4'hF;
    set_word(2, 0, word);
    wait_ack("t5_len0", 4'b0100, 1'b1);
    @(negedge clk);
    check("t5_len0_valid", 64'(bus.lane_valid), 64'h0);
    check("t5_len0_busy", 64'(bus.busy), 64'h0);
    set_word(2, 600, word);
    wait_ack("t5_len600", 4'b0100, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("t5_len600_valid", 64'(bus.lane_valid), 64'h0);
    end
    word = '0; word[15:0] = 16'h1111; set_word(0, 16, word);
    word = '0; word[15:0] = 16'h3333; set_word(3, 16, word);
    wait_ack("t5_g3", 4'b1000, 1'b0);
    exp_b[0] = 32'h0000_3333;
    run_word("t5_w3", 3, 1, 1, 1'b0, 0);
    wait_ack("t5_g0", 4'b0001, 1'b0);
    exp_b[0] = 32'h0000_1111;
    run_word("t5_w0", 0, 1, 1, 1'b0, 0);

    // T6: reset during the fifth beat of a 513-bit word.
    word = '1;
    set_word(0, 513, word);
    wait_ack("t6", 4'b0001, 1'b0);
    for (int b = 0; b < 16; b++) exp_b[b] = 32'hFFFF_FFFF;
    run_word("t6", 0, 4, 17, 1'b0, 0);
    @(negedge clk);
    check("t6_beat5_valid", 64'(bus.lane_valid), 64'h1);
    check("t6_beat5_data", 64'(bus.lane_data), 64'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.lane_valid), 64'h0);
    check("t6_rst_busy", 64'(bus.busy), 64'h0);
    check("t6_rst_data", 64'(bus.lane_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_post_ack", 64'(bus.ack), 64'h0);
    check("t6_post_busy", 64'(bus.busy), 64'h0);
    word = '0; word[15:0] = 16'h5A5A; set_word(0, 16, word);
    word = '0; word[15:0] = 16'hA5A5; set_word(1, 16, word);
    wait_ack("t6_g0", 4'b0001, 1'b0);
    exp_b[0] = 32'h0000_5A5A;
    run_word("t6_w0", 0, 1, 1, 1'b0, 1);
    wait_ack("t6_g1", 4'b0010, 1'b0);
    exp_b[0] = 32'h0000_A5A5;
    run_word("t6_w1", 1, 1, 1, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("t6_end_busy", 64'(bus.busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
